// File: rtl/ws281x_frame_ctrl.sv
// WS281x frame sequencer: fetches pixel words, serialises them MSB-first, then latches.
// Define WS281X_RGBW_EN for 32-bit GRBW pixels; default is 24-bit GRB.
module ws281x_frame_ctrl #(
`ifdef WS281X_RGBW_EN
  localparam int PIX_W = 32
`else
  localparam int PIX_W = 24
`endif
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             frame_start_in,
  input  logic [7:0]       pixel_num_in,
  input  logic [15:0]      rst_cnt_in,
  output logic             pixel_req_out,
  input  logic             pixel_rdy_in,
  input  logic [PIX_W-1:0] pixel_data_in,
  output logic             bit_rdy_out,
  output logic             bit_data_out,
  input  logic             bit_done_in,
  output logic             busy_out,
  output logic             frame_done_out
);

  localparam int BW = $clog2(PIX_W);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_PIX,
    SEND,
    WAIT_BIT,
    LATCH
  } state_t;

  state_t           state;
  logic [7:0]       pix_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [15:0]      lat_cnt;
  logic [15:0]      rst_cnt;
  logic [PIX_W-1:0] shift;
  logic [15:0]      start_lat;
  logic [15:0]      end_lat;

  // A zero latch request still costs one cycle so frame_done has a slot.
  assign start_lat = (rst_cnt_in == 16'd0) ? 16'd1 : rst_cnt_in;
  assign end_lat   = (rst_cnt == 16'd0) ? 16'd1 : rst_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      pix_cnt        <= '0;
      bit_cnt        <= '0;
      lat_cnt        <= '0;
      rst_cnt        <= '0;
      shift          <= '0;
      pixel_req_out  <= 1'b0;
      bit_rdy_out    <= 1'b0;
      bit_data_out   <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      pixel_req_out  <= 1'b0;
      bit_rdy_out    <= 1'b0;
      frame_done_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start_in) begin
            pix_cnt  <= pixel_num_in;
            rst_cnt  <= rst_cnt_in;
            busy_out <= 1'b1;
            if (pixel_num_in != 8'd0) begin
              pixel_req_out <= 1'b1;
              state         <= REQ;
            end else begin
              lat_cnt        <= start_lat;
              bit_data_out   <= 1'b0;
              frame_done_out <= (start_lat == 16'd1);
              state          <= LATCH;
            end
          end
        end
        REQ: state <= WAIT_PIX;
        WAIT_PIX: begin
          if (pixel_rdy_in) begin
            shift        <= pixel_data_in;
            bit_cnt      <= BW'(PIX_W - 1);
            bit_data_out <= pixel_data_in[PIX_W-1];
            bit_rdy_out  <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: state <= WAIT_BIT;
        WAIT_BIT: begin
          if (bit_done_in) begin
            if (bit_cnt != '0) begin
              shift        <= shift << 1;
              bit_cnt      <= bit_cnt - 1'b1;
              bit_data_out <= shift[PIX_W-2];
              bit_rdy_out  <= 1'b1;
              state        <= SEND;
            end else if (pix_cnt != 8'd1) begin
              pix_cnt       <= pix_cnt - 8'd1;
              pixel_req_out <= 1'b1;
              state         <= REQ;
            end else begin
              lat_cnt        <= end_lat;
              bit_data_out   <= 1'b0;
              frame_done_out <= (end_lat == 16'd1);
              state          <= LATCH;
            end
          end
        end
        LATCH: begin
          if (lat_cnt <= 16'd1) begin
            busy_out <= 1'b0;
            state    <= IDLE;
          end else begin
            lat_cnt        <= lat_cnt - 16'd1;
            frame_done_out <= (lat_cnt == 16'd2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws281x_frame_ctrl.sv
// Bench for ws281x_frame_ctrl: directed and random frames against a bit-stream model.
// Build with WS281X_RGBW_EN defined to exercise the 32-bit pixel variant.
module tb_ws281x_frame_ctrl;

`ifdef WS281X_RGBW_EN
  localparam int PIX_W = 32;
  localparam logic [31:0] P_ONE = 32'h0000_0001;
`else
  localparam int PIX_W = 24;
  localparam logic [23:0] P_ONE = 24'hA50000;
`endif

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic             frame_start_in = 1'b0;
  logic [7:0]       pixel_num_in = '0;
  logic [15:0]      rst_cnt_in = '0;
  logic             pixel_req_out;
  logic             pixel_rdy_in = 1'b0;
  logic [PIX_W-1:0] pixel_data_in = '0;
  logic             bit_rdy_out;
  logic             bit_data_out;
  logic             bit_done_in = 1'b0;
  logic             busy_out;
  logic             frame_done_out;

  int checks = 0;
  int failures = 0;
  logic [PIX_W-1:0] pix_q[$];
  bit got_q[$];
  bit exp_q[$];

  ws281x_frame_ctrl dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .frame_start_in(frame_start_in),
    .pixel_num_in(pixel_num_in),
    .rst_cnt_in(rst_cnt_in),
    .pixel_req_out(pixel_req_out),
    .pixel_rdy_in(pixel_rdy_in),
    .pixel_data_in(pixel_data_in),
    .bit_rdy_out(bit_rdy_out),
    .bit_data_out(bit_data_out),
    .bit_done_in(bit_done_in),
    .busy_out(busy_out),
    .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lat 0 means a random latency of 1..4 cycles per event.
  function automatic int pick(input int lat);
    return (lat == 0) ? int'($urandom_range(1, 4)) : lat;
  endfunction

  task automatic run_frame(input int npix, input int rstc, input int up_lat,
                           input int enc_lat, input bit inject,
                           input int abort_bit);
    int cyc, last_cyc, fd_cyc, up_t, enc_t, pidx, nreq, ndone, lat_exp, nbad;
    bit drv_rdy, drv_done, exp_bit, exp_next, ended;
    logic [2:0] want;
    exp_q.delete();
    got_q.delete();
    for (int p = 0; p < npix; p++)
      for (int b = PIX_W - 1; b >= 0; b--)
        exp_q.push_back(pix_q[p][b]);
    lat_exp = (rstc == 0) ? 1 : rstc;
    frame_start_in = 1'b1;
    pixel_num_in = 8'(npix);
    rst_cnt_in = 16'(rstc);
    last_cyc = 0;
    fd_cyc = -1;
    up_t = 0;
    enc_t = 0;
    pidx = 0;
    nreq = 0;
    ndone = 0;
    exp_bit = 0;
    exp_next = 0;
    ended = 0;
    cyc = 1;
    @(posedge clk_in); #1;
    chk("busy_start", busy_out, 1);
    chk("req_start", pixel_req_out, npix != 0);
    while (!ended && cyc < 20000) begin
      if (exp_bit) chk("rdy_to_bit", bit_rdy_out, 1);
      if (exp_next) begin
        if (got_q.size() == exp_q.size()) want = 3'b001;
        else if (got_q.size() % PIX_W == 0) want = 3'b011;
        else want = 3'b101;
        chk("done_to_next", {bit_rdy_out, pixel_req_out, busy_out}, want);
      end
      exp_bit = 0;
      exp_next = 0;
      drv_rdy = 0;
      drv_done = 0;
      if (up_t > 0) begin up_t--; drv_rdy = (up_t == 0); end
      if (enc_t > 0) begin enc_t--; drv_done = (enc_t == 0); end
      if (pixel_req_out) begin nreq++; up_t = pick(up_lat); end
      if (bit_rdy_out) begin
        got_q.push_back(bit_data_out);
        enc_t = pick(enc_lat);
        if (abort_bit >= 0 && got_q.size() == abort_bit + 1) begin
          #2 rst_n_in = 1'b0;
          #1;
          chk("rst_outs", {pixel_req_out, bit_rdy_out, bit_data_out,
                           busy_out, frame_done_out}, 0);
          pixel_rdy_in = 1'b0;
          bit_done_in = 1'b0;
          frame_start_in = 1'b0;
          repeat (3) begin
            @(posedge clk_in); #1;
            chk("rst_hold", {frame_done_out, busy_out}, 0);
          end
          rst_n_in = 1'b1;
          return;
        end
      end
      if (frame_done_out) begin
        ndone++;
        fd_cyc = cyc;
        chk("latch_len", cyc - last_cyc, lat_exp);
        chk("latch_data", bit_data_out, 0);
      end
      if (!busy_out) begin
        chk("busy_fall", cyc, fd_cyc + 1);
        ended = 1;
      end
      pixel_rdy_in = drv_rdy;
      bit_done_in = drv_done;
      frame_start_in = 1'b0;
      if (drv_rdy) begin
        pixel_data_in = (pidx < pix_q.size()) ? pix_q[pidx] : '0;
        pidx++;
        exp_bit = 1;
      end
      if (drv_done) begin
        exp_next = 1;
        last_cyc = cyc;
      end
      if (inject) begin
        if (!drv_rdy && !drv_done && enc_t > 0) begin
          pixel_rdy_in = 1'b1;
          pixel_data_in = PIX_W'($urandom);
        end
        if (!drv_rdy && !drv_done && up_t > 0) bit_done_in = 1'b1;
        if (cyc == 3) begin
          frame_start_in = 1'b1;
          pixel_num_in = 8'hFF;
        end
      end
      // A restart on the frame_done cycle must be dropped.
      if (frame_done_out) begin
        frame_start_in = 1'b1;
        pixel_num_in = 8'd3;
      end
      if (!ended) begin
        @(posedge clk_in); #1;
        cyc++;
      end
    end
    pixel_rdy_in = 1'b0;
    bit_done_in = 1'b0;
    frame_start_in = 1'b0;
    if (!ended) chk("timeout", 1, 0);
    @(posedge clk_in); #1;
    chk("restart_ignored", busy_out, 0);
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) nbad++;
    chk("nbits", got_q.size(), exp_q.size());
    chk("bits_bad", nbad, 0);
    chk("nreq", nreq, npix);
    chk("ndone", ndone, 1);
  endtask

  initial begin
    logic [PIX_W-1:0] w;
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_outs", {pixel_req_out, bit_rdy_out, bit_data_out,
                       busy_out, frame_done_out}, 0);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    pix_q = '{P_ONE};
    run_frame(1, 4, 2, 2, 0, -1);
    w = '0;
    for (int i = 0; i < PIX_W && i < got_q.size(); i++)
      w = {w[PIX_W-2:0], got_q[i]};
    chk("word0", w, P_ONE);
    chk("last_bit", got_q.size() == PIX_W ? got_q[PIX_W-1] : 1'bx, P_ONE[0]);

    pix_q = '{PIX_W'($urandom), PIX_W'($urandom), PIX_W'($urandom)};
    run_frame(3, 2, 3, 1, 0, -1);

    pix_q.delete();
    run_frame(0, 0, 1, 1, 0, -1);

    pix_q = '{PIX_W'($urandom), PIX_W'($urandom)};
    run_frame(2, 3, 3, 3, 1, -1);

    pix_q = '{PIX_W'($urandom)};
    run_frame(1, 5, 2, 2, 0, 10);
    pix_q = '{PIX_W'($urandom)};
    run_frame(1, 2, 1, 1, 0, -1);

    for (int f = 0; f < 6; f++) begin
      int n;
      n = int'($urandom_range(0, 4));
      pix_q.delete();
      for (int p = 0; p < n; p++) pix_q.push_back(PIX_W'($urandom));
      run_frame(n, int'($urandom_range(0, 8)), 0, 0, f[0], -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
